// File: rtl/axi_pkg.sv
// Shared AXI constants, slave state encoding and the strobe-to-bit-write-enable helper
// used by the SRAM slave front-end.
package axi_pkg;

  localparam logic [1:0] BURST_INC   = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  localparam int STRB_MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RISSUE = 3'd1,
    ST_RDATA  = 3'd2,
    ST_WDATA  = 3'd3,
    ST_WRESP  = 3'd4
  } sram_slv_state_t;

  // Active-low per-bit enables: a cleared strobe bit masks its whole byte.
  function automatic logic [8*STRB_MAX_W-1:0] strb_to_bweb(input logic [STRB_MAX_W-1:0] strb);
    logic [8*STRB_MAX_W-1:0] bweb;
    for (int i = 0; i < STRB_MAX_W; i++) begin
      bweb[8*i +: 8] = {8{~strb[i]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/sram_axi_slave.sv
// AXI4 slave front-end for one single-port synchronous SRAM: one INCR burst at a time,
// translated into active-low CEB/WEB/BWEB cycles with R/B responses.
module sram_axi_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                SRAM_CEB,
  output logic                SRAM_WEB,
  output logic [DATA_W-1:0]   SRAM_BWEB,
  output logic [MEM_AW-1:0]   SRAM_A,
  output logic [DATA_W-1:0]   SRAM_DI,
  input  logic [DATA_W-1:0]   SRAM_DO
);

  sram_slv_state_t state_r, state_s;
  logic [ID_W-1:0]   id_r, id_s;
  logic [MEM_AW-1:0] addr_r, addr_s, sram_a_s;
  logic [LEN_W-1:0]  len_r, len_s, beat_r, beat_s;
  logic              err_r, err_s;
  logic              out_en_r;
  logic              ceb_s, web_s;
  logic [DATA_W-1:0] bweb_s;
  logic [8*STRB_MAX_W-1:0] bweb_full_s;
  logic              ar_hs_s, aw_hs_s, rlast_s;
  logic              unused_s;

  // Address handshakes stay low until the first clock after reset release.
  assign AWREADY   = (state_r == ST_IDLE) && out_en_r;
  assign ARREADY   = (state_r == ST_IDLE) && out_en_r && !AWVALID;
  assign aw_hs_s   = AWVALID && AWREADY;
  assign ar_hs_s   = ARVALID && ARREADY;
  assign rlast_s   = (beat_r == len_r);

  assign RVALID    = (state_r == ST_RDATA);
  assign RLAST     = RVALID && rlast_s;
  assign RDATA     = SRAM_DO;
  assign RID       = id_r;
  assign RRESP     = RESP_OKAY;
  assign WREADY    = (state_r == ST_WDATA);
  assign BVALID    = (state_r == ST_WRESP);
  assign BID       = id_r;
  assign BRESP     = err_r ? RESP_SLVERR : RESP_OKAY;

  assign SRAM_CEB  = ceb_s;
  assign SRAM_WEB  = web_s;
  assign SRAM_BWEB = bweb_s;
  assign SRAM_A    = sram_a_s;
  assign SRAM_DI   = WDATA;

  assign bweb_full_s = strb_to_bweb(STRB_MAX_W'(WSTRB));

  // Size and burst type are treated as word INCR; high address bits are decoded upstream.
  assign unused_s = ^{ARADDR, AWADDR, ARSIZE ^ SIZE_WORD, AWSIZE ^ SIZE_WORD,
                      ARBURST ^ BURST_INC, AWBURST ^ BURST_INC, bweb_full_s};

  // Next-state, burst bookkeeping and SRAM strobe generation.
  always_comb begin
    state_s  = state_r;
    id_s     = id_r;
    addr_s   = addr_r;
    len_s    = len_r;
    beat_s   = beat_r;
    err_s    = err_r;
    ceb_s    = 1'b1;
    web_s    = 1'b1;
    bweb_s   = {DATA_W{1'b1}};
    sram_a_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (aw_hs_s) begin
          id_s    = AWID;
          addr_s  = AWADDR[MEM_AW+1:2];
          len_s   = AWLEN;
          beat_s  = {LEN_W{1'b0}};
          err_s   = 1'b0;
          state_s = ST_WDATA;
        end else if (ar_hs_s) begin
          id_s    = ARID;
          addr_s  = ARADDR[MEM_AW+1:2];
          len_s   = ARLEN;
          beat_s  = {LEN_W{1'b0}};
          state_s = ST_RISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RISSUE: begin
        ceb_s   = 1'b0;
        state_s = ST_RDATA;
      end
      ST_RDATA: begin
        // Prefetch the next word on a handshake; a stalled beat re-reads its own word.
        ceb_s = 1'b0;
        if (RREADY) begin
          sram_a_s = addr_r + MEM_AW'(1);
          if (rlast_s) begin
            state_s = ST_IDLE;
          end else begin
            addr_s = addr_r + MEM_AW'(1);
            beat_s = beat_r + LEN_W'(1);
          end
        end else begin
          sram_a_s = addr_r;
        end
      end
      ST_WDATA: begin
        if (WVALID) begin
          ceb_s  = 1'b0;
          web_s  = 1'b0;
          bweb_s = bweb_full_s[DATA_W-1:0];
          addr_s = addr_r + MEM_AW'(1);
          beat_s = beat_r + LEN_W'(1);
          if (WLAST) begin
            state_s = ST_WRESP;
            if (beat_r != len_r) begin
              err_s = 1'b1;
            end else begin
              err_s = err_r;
            end
          end else if (rlast_s) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
        end else begin
          ceb_s = 1'b1;
        end
      end
      ST_WRESP: begin
        if (BREADY) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WRESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Burst state registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r  <= ST_IDLE;
      id_r     <= {ID_W{1'b0}};
      addr_r   <= {MEM_AW{1'b0}};
      len_r    <= {LEN_W{1'b0}};
      beat_r   <= {LEN_W{1'b0}};
      err_r    <= 1'b0;
      out_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      id_r     <= id_s;
      addr_r   <= addr_s;
      len_r    <= len_s;
      beat_r   <= beat_s;
      err_r    <= err_s;
      out_en_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Scoreboard bench for sram_axi_slave: directed bursts push expected R/B beats,
// a negedge monitor compares them whenever the DUT presents a response.
module tb_sram_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [3:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        SRAM_CEB, SRAM_WEB;
  logic [31:0] SRAM_BWEB, SRAM_DI, SRAM_DO;
  logic [13:0] SRAM_A;

  logic [31:0] sram_model [0:16383];

  typedef struct { logic [31:0] data; logic [7:0] id; logic last; } rexp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
  rexp_t exp_r[$];
  bexp_t exp_b[$];

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  sram_axi_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB),
    .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  // Behavioural single-port SRAM with one-cycle read latency
  always @(posedge ACLK) begin
    if (!SRAM_CEB) begin
      if (!SRAM_WEB) sram_model[SRAM_A] <= (sram_model[SRAM_A] & SRAM_BWEB) | (SRAM_DI & ~SRAM_BWEB);
      else           SRAM_DO <= sram_model[SRAM_A];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [7:0] id, input logic last);
    rexp_t e;
    e.data = d; e.id = id; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] id, input logic [1:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  // Monitor: compare every presented R beat (held beats re-checked) and every B handshake
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (RVALID) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected", 32'd1, 32'd0);
        end else begin
          chk("rdata", RDATA, exp_r[0].data);
          chk("rid", {24'd0, RID}, {24'd0, exp_r[0].id});
          chk("rlast", {31'd0, RLAST}, {31'd0, exp_r[0].last});
          chk("rresp", {30'd0, RRESP}, 32'd0);
          if (RREADY) void'(exp_r.pop_front());
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected", 32'd1, 32'd0);
        end else begin
          chk("bid", {24'd0, BID}, {24'd0, exp_b[0].id});
          chk("bresp", {30'd0, BRESP}, {30'd0, exp_b[0].resp});
          void'(exp_b.pop_front());
        end
      end
    end
  end

  function automatic logic sel_rdy(input int k);
    case (k)
      0: return ARREADY;
      1: return AWREADY;
      2: return WREADY;
      3: return BVALID;
      default: return RVALID;
    endcase
  endfunction

  // Wait for the selected ready/valid at a negedge, then step past the handshaking edge
  task automatic wait_hs(input int k, input string name);
    int n = 0;
    forever begin
      @(negedge ACLK);
      if (k == 1 && ARVALID) chk("tie_arready", {31'd0, ARREADY}, 32'd0);
      if (sel_rdy(k)) break;
      n++;
      if (n > 50) begin
        chk({name, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input int stall_beat, input int stall_cycles);
    int b = 0, sc = 0, cyc = 0;
    bit first = 1'b1;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    wait_hs(0, "ar");
    ARVALID = 1'b0;
    while (b <= int'(len) && cyc < 100) begin
      RREADY = (b == stall_beat && sc < stall_cycles) ? 1'b0 : 1'b1;
      @(negedge ACLK);
      cyc++;
      if (RVALID) begin
        if (first) chk("r_latency", cyc, 32'd2);
        first = 1'b0;
        if (RREADY) b++;
        else sc++;
      end
      @(posedge ACLK); #1;
    end
    if (cyc >= 100) chk("r_timeout", 32'd1, 32'd0);
    RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int nbeats, input logic [31:0] base, input logic [3:0] strb);
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    wait_hs(1, "aw");
    AWVALID = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      WDATA = base + 32'h1111_1111 * b;
      WSTRB = strb;
      WLAST = (b == nbeats - 1);
      WVALID = 1'b1;
      wait_hs(2, "w");
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    wait_hs(3, "b");
    BREADY = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0;
    ARID = 8'd0; ARADDR = 32'd0; ARLEN = 4'd0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b0;
    AWID = 8'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; RREADY = 1'b0; BREADY = 1'b0;
    for (int i = 0; i < 16384; i++) sram_model[i] = 32'd0;
    sram_model[14'h010] = 32'hDEAD_BEEF;
    sram_model[14'h040] = 32'h1111_1111;
    sram_model[14'h041] = 32'h2222_2222;
    sram_model[14'h042] = 32'h3333_3333;
    sram_model[14'h043] = 32'h4444_4444;
    sram_model[14'h008] = 32'h1122_3344;
    sram_model[14'h0C2] = 32'h7777_7777;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arready", {31'd0, ARREADY}, 32'd0);
    chk("rst_awready", {31'd0, AWREADY}, 32'd0);
    chk("rst_valids", {28'd0, RVALID, RLAST, WREADY, BVALID}, 32'd0);
    chk("rst_ids", {12'd0, RID, BID, RRESP, BRESP}, 32'd0);
    chk("rst_ceb_web", {30'd0, SRAM_CEB, SRAM_WEB}, 32'd3);
    chk("rst_bweb", SRAM_BWEB, 32'hFFFF_FFFF);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Single-beat read
    push_r(32'hDEAD_BEEF, 8'h12, 1'b1);
    do_read(8'h12, 32'h40, 4'd0, -1, 0);

    // Four-beat read with a 3-cycle stall on the third beat
    push_r(32'h1111_1111, 8'h21, 1'b0);
    push_r(32'h2222_2222, 8'h21, 1'b0);
    push_r(32'h3333_3333, 8'h21, 1'b0);
    push_r(32'h4444_4444, 8'h21, 1'b1);
    do_read(8'h21, 32'h100, 4'd3, 2, 3);

    // Partial-strobe write: bytes 0 and 2 updated
    push_b(8'h33, 2'b00);
    do_write(8'h33, 32'h20, 4'd0, 1, 32'hAABB_CCDD, 4'b0101);
    push_r(32'h11BB_33DD, 8'h34, 1'b1);
    do_read(8'h34, 32'h20, 4'd0, -1, 0);

    // AR and AW presented together: write first, read returns the new data
    ARID = 8'h45; ARADDR = 32'h200; ARLEN = 4'd0; ARVALID = 1'b1;
    push_b(8'h44, 2'b00);
    do_write(8'h44, 32'h200, 4'd0, 1, 32'hCAFE_F00D, 4'hF);
    push_r(32'hCAFE_F00D, 8'h45, 1'b1);
    do_read(8'h45, 32'h200, 4'd0, -1, 0);

    // Early WLAST on a LEN 3 burst: two beats written, SLVERR, third word untouched
    push_b(8'h55, 2'b10);
    do_write(8'h55, 32'h300, 4'd3, 2, 32'h5555_5555, 4'hF);
    push_r(32'h5555_5555, 8'h56, 1'b0);
    push_r(32'h6666_6666, 8'h56, 1'b0);
    push_r(32'h7777_7777, 8'h56, 1'b1);
    do_read(8'h56, 32'h300, 4'd2, -1, 0);

    // Reset pulse during the second beat of a read burst
    push_r(32'h1111_1111, 8'h66, 1'b0);
    push_r(32'h2222_2222, 8'h66, 1'b0);
    ARID = 8'h66; ARADDR = 32'h100; ARLEN = 4'd3; ARVALID = 1'b1;
    wait_hs(0, "ar_rst");
    ARVALID = 1'b0;
    RREADY = 1'b1;
    wait_hs(4, "rvalid_rst");
    RREADY = 1'b0;
    #2;
    ARESETn = 1'b0;
    #1;
    chk("midrst_rvalid", {31'd0, RVALID}, 32'd0);
    chk("midrst_ceb", {31'd0, SRAM_CEB}, 32'd1);
    exp_r.delete();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("postrst_rvalid", {31'd0, RVALID}, 32'd0);
    push_r(32'h1111_1111, 8'h67, 1'b0);
    push_r(32'h2222_2222, 8'h67, 1'b0);
    push_r(32'h3333_3333, 8'h67, 1'b0);
    push_r(32'h4444_4444, 8'h67, 1'b1);
    do_read(8'h67, 32'h100, 4'd3, -1, 0);

    // Word-address wrap from 0x3FFF to 0x0000; high read address bits ignored
    push_b(8'h77, 2'b00);
    do_write(8'h77, 32'hFFFC, 4'd1, 2, 32'h0101_0101, 4'hF);
    chk("wrap_mem_3fff", sram_model[14'h3FFF], 32'h0101_0101);
    chk("wrap_mem_0000", sram_model[14'h0000], 32'h1212_1212);
    push_r(32'h0101_0101, 8'h78, 1'b0);
    push_r(32'h1212_1212, 8'h78, 1'b1);
    do_read(8'h78, 32'h8000_FFFC, 4'd1, -1, 0);

    repeat (2) @(posedge ACLK);
    chk("r_queue_empty", exp_r.size(), 32'd0);
    chk("b_queue_empty", exp_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
